axis_sat_packer: RTL and testbench
==================================

// Module: axis_sat_packer
// PURPOSE
//  Downstream consumer of the FIR wrapper's 32-bit signed AXIS output stream.
//  - Arithmetic-shifts each sample, then saturates it to OUT_W bits.
//  - Packs two samples into one 32-bit AXIS word for DMA.
//  - Carries frame boundaries (tlast) through and pads a trailing odd sample.
//  Single clock domain; sits between the FIR chain and the S2MM DMA.
// PARAMETERS
//  C_S00_AXIS_TDATA_WIDTH  32  input sample width, signed two's complement
//  C_M00_AXIS_TDATA_WIDTH  32  output word width; must equal 2*OUT_W
//  OUT_W                   16  packed sample width after saturation
//  SHIFT                   0   arithmetic right shift applied before clipping (0..31)
// PORTS
//  s00_axis_aclk     in   1       sole clock for both interfaces
//  s00_axis_aresetn  in   1       reset; asynchronous, active-low
//  s00_axis_tdata    in   32      signed input sample
//  s00_axis_tstrb    in   4       ignored
//  s00_axis_tvalid   in   1       input valid
//  s00_axis_tlast    in   1       last sample of frame
//  s00_axis_tready   out  1       input ready
//  m00_axis_tready   in   1       downstream ready
//  m00_axis_tvalid   out  1       output word valid
//  m00_axis_tlast    out  1       last word of frame
//  m00_axis_tdata    out  32      {sample_hi, sample_lo}, each OUT_W signed
//  m00_axis_tstrb    out  4       byte strobes
// BEHAVIOUR
//  - Reset (aresetn low, async):
//    - m00_axis_tvalid, m00_axis_tlast, m00_axis_tdata and m00_axis_tstrb = 0.
//    - state = LO; held low-half sample discarded.
//    - s00_axis_tready forced 0 while reset is asserted.
//  - Arithmetic: y = $signed(x) >>> SHIFT in 32 bits, then clip to
//    [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Clip bounds are 0x8000 and 0x7FFF for OUT_W=16.
//  - Handshake:
//    - Ready rule: s00_axis_tready = !m00_axis_tvalid || m00_axis_tready.
//      Registered output slot, so full throughput when m00_axis_tready is held 1.
//    - Accept occurs on s00_axis_tvalid && s00_axis_tready.
//    - While m00_axis_tvalid=1 && m00_axis_tready=0, m00_axis_tdata,
//      m00_axis_tlast and m00_axis_tstrb stay stable.
//    - m00_axis_tvalid drops on a transfer unless a new word is loaded in that same cycle.
//  - FSM (2 states):
//    - LO, accept, !tlast: clipped sample -> lo_reg; go to HI; no output.
//    - LO, accept, tlast: load output {0, clip}; tstrb=4'b0011; tlast=1; stay in LO.
//    - HI, accept: load output {clip, lo_reg}; tstrb=4'b1111; tlast=s00_axis_tlast; go to LO.
//  - Latency: word valid 1 cycle after the accepting edge of its second (or odd-last) sample.
//  - Simultaneous drain + load: the old word transfers and the new word is registered
//    on the same edge; m00_axis_tvalid stays 1.
//  - Reset mid-pair: a held low sample is dropped; the first word after reset uses
//    only post-reset samples.
// CONFIGURATION
//  SAT_COUNT_EN defined:
//  - Adds port sat_count (out, 16): number of accepted samples that were clipped.
//  - Counter saturates at 0xFFFF; async-cleared to 0 by reset.
//  SAT_COUNT_EN undefined:
//  - Port and counter are absent; datapath behaviour is identical.
// TESTING
//  1 SHIFT=0, m00_axis_tready=1; in 5, -3 (no tlast)
//    -> one word 0xFFFD0005, tstrb 0xF, tlast 0.
//  2 In 40000, -40000 -> word 0x80007FFF; with SAT_COUNT_EN, sat_count=2.
//  3 In 1, 2, 3(tlast) -> 0x00020001 (tlast 0, tstrb 0xF),
//    then 0x00000003 (tlast 1, tstrb 0x3).
//  4 Hold m00_axis_tready=0 for 5 cycles while a word is valid
//    -> tdata/tvalid stable, s00_axis_tready=0, no sample lost after release.
//  5 Accept 7, pulse aresetn low mid-pair, then send 8, 9
//    -> first word 0x00090008, no 7 emitted.
//  6 SHIFT=12; in 0x00123000, 0xFFFFF000
//    -> word 0xFFFF0123; in 0x7FFFFFFF -> clipped low half 0x7FFF.

Source files
------------

// File: rtl/axis_sat_packer.sv
// Shift, saturate and pack two signed samples per 32-bit AXIS word.
// Optional clip counter port sat_count when SAT_COUNT_EN is defined.
module axis_sat_packer #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int OUT_W                  = 16,
  parameter int SHIFT                  = 0
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                                s00_axis_tvalid,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
`ifdef SAT_COUNT_EN
  output logic [15:0]                         sat_count,
`endif
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

  localparam int DW = C_S00_AXIS_TDATA_WIDTH;
  localparam int MW = C_M00_AXIS_TDATA_WIDTH;
  localparam int SW = MW / 8;

  localparam logic signed [DW-1:0] MAXV =
    DW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [DW-1:0] MINV =
    -MAXV - 1;

  localparam logic [SW-1:0] STRB_LO =
    SW'((1 << (OUT_W / 8)) - 1);
  localparam logic [SW-1:0] STRB_ALL = '1;

  localparam logic ST_LO = 1'b0;
  localparam logic ST_HI = 1'b1;

  logic                   r_state;
  logic [OUT_W-1:0]       r_lo;
  logic                   r_tvalid;
  logic                   r_tlast;
  logic [MW-1:0]          r_tdata;
  logic [SW-1:0]          r_tstrb;

  logic signed [DW-1:0]   w_shifted;
  logic [OUT_W-1:0]       w_sample;
  logic                   w_clipped;
  logic                   w_accept;
  logic                   w_load;
  logic [MW-1:0]          w_word;
  logic [SW-1:0]          w_strb;
  logic                   w_unused_tstrb;

  assign w_unused_tstrb = ^s00_axis_tstrb;

  assign s00_axis_tready = s00_axis_aresetn &&
                           (!r_tvalid || m00_axis_tready);

  assign w_accept = s00_axis_tvalid && s00_axis_tready;
  assign w_load   = w_accept &&
                    (r_state == ST_HI || s00_axis_tlast);

  assign w_shifted = $signed(s00_axis_tdata) >>> SHIFT;

  // Clip the shifted sample into the signed OUT_W range
  always_comb begin
    w_sample  = w_shifted[OUT_W-1:0];
    w_clipped = 1'b0;
    unique case (1'b1)
      (w_shifted > MAXV): begin
        w_sample  = MAXV[OUT_W-1:0];
        w_clipped = 1'b1;
      end
      (w_shifted < MINV): begin
        w_sample  = MINV[OUT_W-1:0];
        w_clipped = 1'b1;
      end
      default: ;
    endcase
  end

  // Build the word to load: a full pair, or a padded odd tail
  always_comb begin
    w_word = '0;
    w_strb = STRB_LO;
    if (r_state == ST_HI) begin
      w_word = {w_sample, r_lo};
      w_strb = STRB_ALL;
    end else begin
      w_word[OUT_W-1:0] = w_sample;
    end
  end

  // Pair-position state and held low-half sample
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_state <= ST_LO;
      r_lo    <= '0;
    end else if (w_accept) begin
      if (r_state == ST_LO && !s00_axis_tlast) begin
        r_lo    <= w_sample;
        r_state <= ST_HI;
      end else begin
        r_state <= ST_LO;
      end
    end
  end

  // Registered output slot; holds steady under backpressure
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
      r_tstrb  <= '0;
    end else if (w_load) begin
      r_tvalid <= 1'b1;
      r_tlast  <= s00_axis_tlast;
      r_tdata  <= w_word;
      r_tstrb  <= w_strb;
    end else if (m00_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign m00_axis_tvalid = r_tvalid;
  assign m00_axis_tlast  = r_tlast;
  assign m00_axis_tdata  = r_tdata;
  assign m00_axis_tstrb  = r_tstrb;

`ifdef SAT_COUNT_EN
  logic [15:0] r_sat_cnt;

  // Count clipped accepted samples, sticking at all-ones
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      r_sat_cnt <= '0;
    end else if (w_accept && w_clipped &&
                 r_sat_cnt != 16'hFFFF) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign sat_count = r_sat_cnt;
`else
  logic w_unused_clip;
  assign w_unused_clip = w_clipped;
`endif

endmodule

// File: tb/tb_axis_sat_packer.sv
// Self-checking bench for axis_sat_packer.
// Table vectors, corner sequences and a randomized scoreboard.
module tb_axis_sat_packer;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tvalid;
  logic        s_tlast;
  logic        a_s_tready;
  logic        b_s_tready;
  logic        a_m_tready;
  logic        b_m_tready;
  logic        a_tvalid;
  logic        b_tvalid;
  logic        a_tlast;
  logic        b_tlast;
  logic [31:0] a_tdata;
  logic [31:0] b_tdata;
  logic [3:0]  a_tstrb;
  logic [3:0]  b_tstrb;
`ifdef SAT_COUNT_EN
  logic [15:0] a_sat;
  logic [15:0] b_sat;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int exp_sat = 0;

  logic [36:0] qa[$];
  logic [36:0] qb[$];

  axis_sat_packer #(.SHIFT(0)) u_a (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tready  (a_s_tready),
    .m00_axis_tready  (a_m_tready),
    .m00_axis_tvalid  (a_tvalid),
    .m00_axis_tlast   (a_tlast),
    .m00_axis_tdata   (a_tdata),
`ifdef SAT_COUNT_EN
    .sat_count        (a_sat),
`endif
    .m00_axis_tstrb   (a_tstrb)
  );

  axis_sat_packer #(.SHIFT(12)) u_b (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tvalid  (s_tvalid && a_s_tready),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tready  (b_s_tready),
    .m00_axis_tready  (b_m_tready),
    .m00_axis_tvalid  (b_tvalid),
    .m00_axis_tlast   (b_tlast),
    .m00_axis_tdata   (b_tdata),
`ifdef SAT_COUNT_EN
    .sat_count        (b_sat),
`endif
    .m00_axis_tstrb   (b_tstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always begin
    @(negedge clk);
    #2;
    if (a_tvalid && a_m_tready)
      qa.push_back({a_tlast, a_tstrb, a_tdata});
    if (b_tvalid && b_m_tready)
      qb.push_back({b_tlast, b_tstrb, b_tdata});
  end

  function automatic logic [15:0] clip(
    input logic [31:0] x, input int sh);
    int v;
    v = $signed(x) >>> sh;
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  function automatic bit clips(input logic [31:0] x);
    int v;
    v = $signed(x);
    return (v > 32767) || (v < -32768);
  endfunction

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    #1;
    while (!a_s_tready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got tready 0 expected 1");
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    if (clips(d) && exp_sat < 65535) exp_sat++;
  endtask

  task automatic expect_word(input int which, input string nm,
                             input logic [31:0] d,
                             input logic l,
                             input logic [3:0] st);
    int n;
    logic [36:0] w;
    n = 0;
    while (((which == 0) ? qa.size() : qb.size()) == 0 &&
           n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 100) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got no word expected %0h", nm, d);
    end else begin
      w = (which == 0) ? qa.pop_front() : qb.pop_front();
      check({nm, "_data"}, 64'(w[31:0]), 64'(d));
      check({nm, "_last"}, 64'(w[36]), 64'(l));
      check({nm, "_strb"}, 64'(w[35:32]), 64'(st));
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[6];

  logic [36:0] mq[$];
  bit          m_run;

  initial begin
    vt[0] = '{32'd5,        32'hFFFFFFFD, 32'hFFFD0005};
    vt[1] = '{32'd40000,    -32'sd40000,  32'h80007FFF};
    vt[2] = '{32'd32767,    -32'sd32768,  32'h80007FFF};
    vt[3] = '{32'd32768,    -32'sd32769,  32'h80007FFF};
    vt[4] = '{32'd0,        32'hFFFFFFFF, 32'hFFFF0000};
    vt[5] = '{32'h7FFFFFFF, 32'h80000000, 32'h80007FFF};

    rst_n      = 1'b0;
    s_tdata    = '0;
    s_tstrb    = 4'hF;
    s_tvalid   = 1'b0;
    s_tlast    = 1'b0;
    a_m_tready = 1'b1;
    b_m_tready = 1'b1;
    m_run      = 1'b0;

    settle(2);
    #1;
    check("rst_tvalid", 64'(a_tvalid), 64'd0);
    check("rst_tdata",  64'(a_tdata),  64'd0);
    check("rst_tstrb",  64'(a_tstrb),  64'd0);
    check("rst_tlast",  64'(a_tlast),  64'd0);
    check("rst_sready", 64'(a_s_tready), 64'd0);
    rst_n = 1'b1;
    settle(1);
    #1;
    check("post_rst_sready", 64'(a_s_tready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      send(vt[i].a, 1'b0);
      send(vt[i].b, 1'b0);
      expect_word(0, $sformatf("vec%0d", i),
                  vt[i].exp, 1'b0, 4'hF);
    end
`ifdef SAT_COUNT_EN
    check("sat_count_vec", 64'(a_sat), 64'(exp_sat));
`endif

    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b1);
    expect_word(0, "odd_pair", 32'h00020001, 1'b0, 4'hF);
    expect_word(0, "odd_tail", 32'h00000003, 1'b1, 4'h3);

    a_m_tready = 1'b0;
    send(32'd10, 1'b0);
    send(32'd11, 1'b0);
    #1;
    s_tdata  = 32'd12;
    s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_tvalid", 64'(a_tvalid), 64'd1);
      check("bp_tdata",  64'(a_tdata),  64'h000B000A);
      check("bp_sready", 64'(a_s_tready), 64'd0);
    end
    a_m_tready = 1'b1;
    send(32'd12, 1'b0);
    send(32'd13, 1'b0);
    expect_word(0, "bp_w0", 32'h000B000A, 1'b0, 4'hF);
    expect_word(0, "bp_w1", 32'h000D000C, 1'b0, 4'hF);

    send(32'd7, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_sready", 64'(a_s_tready), 64'd0);
    settle(1);
    rst_n = 1'b1;
    exp_sat = 0;
`ifdef SAT_COUNT_EN
    check("midrst_sat", 64'(a_sat), 64'd0);
`endif
    send(32'd8, 1'b0);
    send(32'd9, 1'b0);
    expect_word(0, "midrst_w", 32'h00090008, 1'b0, 4'hF);
    settle(4);
    check("midrst_extra", 64'(qa.size()), 64'd0);

    qb.delete();
    send(32'h00123000, 1'b0);
    send(32'hFFFFF000, 1'b0);
    expect_word(1, "shift12", 32'hFFFF0123, 1'b0, 4'hF);
    send(32'h7FFFFFFF, 1'b1);
    expect_word(1, "shift12_clip", 32'h00007FFF, 1'b1, 4'h3);
    settle(3);
    qa.delete();
    qb.delete();

    begin
      bit have_lo;
      logic [15:0] lo;
      logic [31:0] d;
      logic l;
      logic [15:0] c;
      have_lo = 1'b0;
      lo = '0;
      m_run = 1'b1;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 3) == 0)
          d = $urandom;
        else
          d = 32'($signed($urandom_range(0, 80000)) - 40000);
        l = ($urandom_range(0, 7) == 0);
        c = clip(d, 0);
        if (have_lo) begin
          mq.push_back({l, 4'hF, c, lo});
          have_lo = 1'b0;
        end else if (l) begin
          mq.push_back({1'b1, 4'h3, 16'h0000, c});
        end else begin
          lo = c;
          have_lo = 1'b1;
        end
        send(d, l);
      end
      if (have_lo) begin
        send(32'd0, 1'b1);
        mq.push_back({1'b1, 4'hF, 16'h0000, lo});
      end
      m_run = 1'b0;
      @(negedge clk);
      a_m_tready = 1'b1;
      while (mq.size() > 0) begin
        logic [36:0] e;
        e = mq.pop_front();
        expect_word(0, "rand", e[31:0], e[36], e[35:32]);
      end
    end
`ifdef SAT_COUNT_EN
    check("sat_count_rand", 64'(a_sat), 64'(exp_sat));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  always begin
    @(negedge clk);
    if (m_run)
      a_m_tready = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
